// File: rtl/keypad_collector_pkg.sv
// Shared types and constants for the keypad collector and its consumers.
package keypad_collector_pkg;

    localparam int unsigned N_DIGITOS = 20;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // digits[0] is the most recent key; unused positions hold 4'hF.
    typedef logic [N_DIGITOS-1:0][3:0] senha_pac_t;

    localparam senha_pac_t SENHA_SKIP    = {N_DIGITOS{4'hF}};
    localparam senha_pac_t SENHA_EXIT    = {N_DIGITOS{4'hB}};
    localparam senha_pac_t SENHA_TIMEOUT = {N_DIGITOS{4'hE}};

    typedef enum logic [0:0] {
        StVazio,
        StDigitando
    } collector_state_e;

endpackage

// File: rtl/keypad_collector_inactivity_timer.sv
// Inactivity timer: counts while run is high and pulses expire on the last count.
module keypad_collector_inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned Width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [Width-1:0] LastCount = Width'(TIMEOUT_CYCLES - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == LastCount);

    // Next count: clear has priority, wrap to zero on expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_collector.sv
// Keypad collector: accumulates decoded digits and emits one packet per
// confirm, exit or inactivity timeout.
module keypad_collector
    import keypad_collector_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_S   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [79:0] digitos_value,
    output logic        digitos_valid
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ * TIMEOUT_S;

    collector_state_e state_q, state_d;
    senha_pac_t       buf_q, buf_d;
    senha_pac_t       value_q, value_d;
    senha_pac_t       pkt;
    logic             valid_q;
    logic             emit;
    logic             tmr_clear, tmr_run, tmr_expire;
    logic             key_digit, key_star, key_hash;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_star  = key_valid && (key_code == KEY_STAR);
    assign key_hash  = key_valid && (key_code == KEY_HASH);

    assign tmr_run = enable && (state_q == StDigitando);

    keypad_collector_inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expire (tmr_expire)
    );

    // Next state, buffer update and emit decision; keys take priority over expiry.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        emit      = 1'b0;
        pkt       = SENHA_SKIP;
        tmr_clear = 1'b0;
        if (!enable) begin
            state_d   = StVazio;
            buf_d     = SENHA_SKIP;
            tmr_clear = 1'b1;
        end else begin
            unique case (state_q)
                StVazio: begin
                    tmr_clear = 1'b1;
                    if (key_digit) begin
                        buf_d   = {buf_q[N_DIGITOS-2:0], key_code};
                        state_d = StDigitando;
                    end else if (key_hash) begin
                        emit = 1'b1;
                        pkt  = SENHA_SKIP;
                    end else if (key_star) begin
                        emit = 1'b1;
                        pkt  = SENHA_EXIT;
                    end
                end
                StDigitando: begin
                    if (key_digit) begin
                        buf_d     = {buf_q[N_DIGITOS-2:0], key_code};
                        tmr_clear = 1'b1;
                    end else if (key_hash) begin
                        emit      = 1'b1;
                        pkt       = buf_q;
                        buf_d     = SENHA_SKIP;
                        state_d   = StVazio;
                        tmr_clear = 1'b1;
                    end else if (key_star) begin
                        buf_d     = SENHA_SKIP;
                        state_d   = StVazio;
                        tmr_clear = 1'b1;
                    end else if (tmr_expire) begin
                        emit      = 1'b1;
                        pkt       = SENHA_TIMEOUT;
                        buf_d     = SENHA_SKIP;
                        state_d   = StVazio;
                        tmr_clear = 1'b1;
                    end
                end
                default: begin
                    state_d = StVazio;
                    buf_d   = SENHA_SKIP;
                end
            endcase
        end
        value_d = emit ? pkt : buf_d;
    end

    // State, buffer and registered output with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StVazio;
            buf_q   <= SENHA_SKIP;
            value_q <= SENHA_SKIP;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            value_q <= value_d;
            valid_q <= emit;
        end
    end

    assign digitos_value = value_q;
    assign digitos_valid = valid_q;

endmodule

// File: tb/tb_keypad_collector.sv
// Directed self-checking bench for keypad_collector (10-cycle timeout).
module tb_keypad_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [79:0] digitos_value;
    logic        digitos_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [79:0] ALL_F = {20{4'hF}};
    localparam logic [79:0] ALL_B = {20{4'hB}};
    localparam logic [79:0] ALL_E = {20{4'hE}};

    keypad_collector #(
        .CLK_FREQ_HZ(10),
        .TIMEOUT_S  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One key pulse sampled on the next edge; returns #1 after that edge.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(2);
        check("reset_valid", {79'd0, digitos_valid}, 80'd0);
        check("reset_value", digitos_value, ALL_F);
        rst = 1'b1;
        idle(1);

        // 1: digits then confirm
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("live_buffer", digitos_value, 80'hFFFFFFFFFFFFFFFF1234);
        check("live_no_valid", {79'd0, digitos_valid}, 80'd0);
        press(4'hB);
        check("confirm_valid", {79'd0, digitos_valid}, 80'd1);
        check("confirm_value", digitos_value, 80'hFFFFFFFFFFFFFFFF1234);
        idle(1);
        check("confirm_after_valid", {79'd0, digitos_valid}, 80'd0);
        check("confirm_after_value", digitos_value, ALL_F);

        // 2: empty-buffer '#' and '*'
        press(4'hB);
        check("skip_valid", {79'd0, digitos_valid}, 80'd1);
        check("skip_value", digitos_value, ALL_F);
        press(4'hA);
        check("exit_valid", {79'd0, digitos_valid}, 80'd1);
        check("exit_value", digitos_value, ALL_B);
        idle(1);

        // 3a: timeout after 10 idle cycles
        press(4'h7); press(4'h8);
        idle(9);
        check("pre_timeout_no_valid", {79'd0, digitos_valid}, 80'd0);
        check("pre_timeout_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFF78);
        idle(1);
        check("timeout_valid", {79'd0, digitos_valid}, 80'd1);
        check("timeout_value", digitos_value, ALL_E);
        idle(1);
        check("timeout_after_value", digitos_value, ALL_F);

        // 3b: key on the expiry edge wins and restarts the timer
        press(4'h7); press(4'h8);
        idle(9);
        press(4'h5);
        check("key_beats_timeout_valid", {79'd0, digitos_valid}, 80'd0);
        check("key_beats_timeout_value", digitos_value, 80'hFFFFFFFFFFFFFFFFF785);
        idle(9);
        check("restart_no_valid", {79'd0, digitos_valid}, 80'd0);
        idle(1);
        check("restart_timeout_valid", {79'd0, digitos_valid}, 80'd1);
        check("restart_timeout_value", digitos_value, ALL_E);
        idle(1);

        // Ignored code neither shifts nor restarts the timer
        press(4'h7);
        idle(5);
        press(4'hC);
        check("ignored_code_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF7);
        idle(3);
        check("ignored_no_valid", {79'd0, digitos_valid}, 80'd0);
        idle(1);
        check("ignored_timeout_valid", {79'd0, digitos_valid}, 80'd1);
        check("ignored_timeout_value", digitos_value, ALL_E);
        idle(1);

        // 4: '*' clears without emitting, then '#' skips
        press(4'h5);
        press(4'hA);
        check("star_clear_valid", {79'd0, digitos_valid}, 80'd0);
        check("star_clear_value", digitos_value, ALL_F);
        press(4'hB);
        check("star_then_hash_valid", {79'd0, digitos_valid}, 80'd1);
        check("star_then_hash_value", digitos_value, ALL_F);
        idle(1);

        // 4: 22 digits, oldest two dropped
        for (int i = 0; i < 20; i++) press(4'(i % 10));
        press(4'h1); press(4'h2);
        press(4'hB);
        check("overflow_valid", {79'd0, digitos_valid}, 80'd1);
        check("overflow_value", digitos_value, 80'h23456789012345678912);
        idle(1);

        // 5: enable low discards silently
        press(4'h3); press(4'h4);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        check("disable_valid", {79'd0, digitos_valid}, 80'd0);
        check("disable_value", digitos_value, ALL_F);
        press(4'hB);
        check("disable_hash_valid", {79'd0, digitos_valid}, 80'd1);
        check("disable_hash_value", digitos_value, ALL_F);
        idle(1);

        // 5: reset mid-entry
        press(4'h6); press(4'h7);
        rst = 1'b0;
        idle(1);
        check("midreset_valid", {79'd0, digitos_valid}, 80'd0);
        check("midreset_value", digitos_value, ALL_F);
        rst = 1'b1;
        idle(1);
        check("midreset_after_valid", {79'd0, digitos_valid}, 80'd0);
        press(4'hB);
        check("midreset_hash_value", digitos_value, ALL_F);
        idle(1);

        // 6: back-to-back pulses
        key_valid = 1'b1;
        key_code  = 4'h9;
        @(posedge clk); #1;
        key_code  = 4'h9;
        @(posedge clk); #1;
        key_code  = 4'hB;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("b2b_valid", {79'd0, digitos_valid}, 80'd1);
        check("b2b_value", digitos_value, 80'hFFFFFFFFFFFFFFFFFF99);
        idle(1);
        check("b2b_single_pulse", {79'd0, digitos_valid}, 80'd0);
        check("b2b_after_value", digitos_value, ALL_F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
